// File: rtl/example7_checker.sv
// Response monitor for the example7 gate network: sweeps {a,b,c,d,e,f}, waits SETTLE
// cycles per vector, samples Y1/Y2 and counts vectors that disagree with the golden model.
module example7_checker #(
    parameter int unsigned SETTLE = 2,
    parameter int unsigned NVEC   = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [5:0] vec,
    input  logic       y1_in,
    input  logic       y2_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] err_count,
    output logic [5:0] first_err_vec,
    output logic       first_err_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [3:0] SETTLE_L = 4'(SETTLE);
    localparam logic [5:0] LAST_VEC = 6'(NVEC - 1);
    localparam logic [6:0] ERR_MAX  = 7'd127;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [5:0] vec_q, vec_d;
    logic [6:0] err_q, err_d;
    logic [5:0] fev_q, fev_d;
    logic       fv_q, fv_d;
    logic       busy_q, done_q, pass_q;

    logic       gold_y1, gold_y2;
    logic       mismatch;

    // Golden example7 network; vec is {a,b,c,d,e,f} with a in bit 5.
    always_comb begin
        gold_y1  = ~(vec_q[5] | vec_q[3] | vec_q[2] | vec_q[1]);
        gold_y2  = ~vec_q[4] & (vec_q[3] | vec_q[2] | vec_q[1]) & vec_q[0];
        mismatch = (y1_in != gold_y1) || (y2_in != gold_y2);
    end

    always_comb begin
        // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        err_d   = err_q;
        fev_d   = fev_q;
        fv_d    = fv_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_WAIT;
                    vec_d   = '0;
                    cnt_d   = SETTLE_L;
                    err_d   = '0;
                    fev_d   = '0;
                    fv_d    = 1'b0;
                end
            end

            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_CHECK;
                end
            end

            S_CHECK: begin
                // Y1/Y2 are only trusted here, after the settle window has elapsed.
                if (mismatch) begin
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + 7'd1;
                    end
                    if (!fv_q) begin
                        fev_d = vec_q;
                        fv_d  = 1'b1;
                    end
                end
                if (vec_q == LAST_VEC) begin
                    state_d = S_DONE;
                end else begin
                    vec_d   = vec_q + 6'd1;
                    cnt_d   = SETTLE_L;
                    state_d = S_WAIT;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments only, so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            err_q   <= '0;
            fev_q   <= '0;
            fv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            fev_q   <= fev_d;
            fv_q    <= fv_d;
            // Flags are registered from the next state so they line up with it.
            busy_q  <= (state_d == S_WAIT) || (state_d == S_CHECK);
            done_q  <= (state_d == S_DONE);
            pass_q  <= (state_d == S_DONE) && (err_d == '0);
        end
    end

    assign vec             = vec_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err_vec   = fev_q;
    assign first_err_valid = fv_q;

endmodule
